// File: rtl/mips_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : mips_perf_monitor
// Purpose  : Cycle/event counters for the pipelined MIPS core with
//            branch-to-self halt detection, watchdog timeout and atomic
//            counter snapshots.
// Revision : 1.0 - initial release
// ============================================================================
module mips_perf_monitor #(
  parameter int CNT_WIDTH      = 32,
  parameter int NUM_EVENTS     = 4,
  parameter int HALT_REPEAT    = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int PC_WIDTH       = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             clear,
  input  logic [NUM_EVENTS-1:0]            event_in,
  input  logic [PC_WIDTH-1:0]              pc_IF,
  input  logic                             snap_req,
  output logic [CNT_WIDTH-1:0]             cycle_count,
  output logic [NUM_EVENTS*CNT_WIDTH-1:0]  event_counts,
  output logic [CNT_WIDTH-1:0]             snap_cycle,
  output logic [NUM_EVENTS*CNT_WIDTH-1:0]  snap_events,
  output logic                             snap_valid,
  output logic                             running,
  output logic                             halted,
  output logic                             timeout
);

  localparam int                   REP_W     = $clog2(HALT_REPEAT + 1);
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);
  localparam logic [REP_W-1:0]     C_REP_MAX = REP_W'(HALT_REPEAT);
  localparam logic [REP_W-1:0]     C_REP_ONE = REP_W'(1);
  // A timeout value that cannot be represented in the counter can never be
  // reached (the counter saturates below it), so the watchdog is disabled.
  localparam bit                   C_TO_EN   = (TIMEOUT_CYCLES != 0) &&
                                               ((64'(TIMEOUT_CYCLES) >> CNT_WIDTH) == 64'd0);
  localparam logic [CNT_WIDTH-1:0] C_TO_VAL  = CNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_HALT    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t                            state_q, state_d;
  logic [CNT_WIDTH-1:0]              cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]              ev_q [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]              ev_d [NUM_EVENTS];
  logic [PC_WIDTH-1:0]               pc_prev_q, pc_prev_d;
  logic [REP_W-1:0]                  rep_q, rep_d;
  logic [CNT_WIDTH-1:0]              snap_cycle_q, snap_cycle_d;
  logic [NUM_EVENTS*CNT_WIDTH-1:0]   snap_ev_q, snap_ev_d;
  logic                              snap_valid_q, snap_valid_d;
  logic [NUM_EVENTS*CNT_WIDTH-1:0]   w_ev_packed;

  // Flatten the live event counters onto the packed output bus.
  generate
    for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_pack
      assign w_ev_packed[gi*CNT_WIDTH +: CNT_WIDTH] = ev_q[gi];
    end
  endgenerate

  // Next-state logic: snapshot capture, soft clear, counting and transitions.
  always_comb begin
    state_d      = state_q;
    cycle_d      = cycle_q;
    ev_d         = ev_q;
    pc_prev_d    = pc_prev_q;
    rep_d        = rep_q;
    snap_cycle_d = snap_cycle_q;
    snap_ev_d    = snap_ev_q;
    snap_valid_d = snap_req;

    // Snapshot sees the pre-edge counters, so it also keeps pre-clear values.
    if (snap_req) begin
      snap_cycle_d = cycle_q;
      snap_ev_d    = w_ev_packed;
    end

    if (clear) begin
      state_d   = S_IDLE;
      cycle_d   = '0;
      pc_prev_d = '0;
      rep_d     = '0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
        ev_d[i] = '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (enable) begin
            if (cycle_q != C_CNT_MAX) begin
              cycle_d = cycle_q + C_CNT_ONE;
            end
            for (int i = 0; i < NUM_EVENTS; i++) begin
              if (event_in[i] && (ev_q[i] != C_CNT_MAX)) begin
                ev_d[i] = ev_q[i] + C_CNT_ONE;
              end
            end
            pc_prev_d = pc_IF;
            if (pc_IF == pc_prev_q) begin
              rep_d = (rep_q == C_REP_MAX) ? rep_q : rep_q + C_REP_ONE;
            end else begin
              rep_d = '0;
            end
            // Halt outranks the watchdog when both fire on the same edge.
            if (rep_d == C_REP_MAX) begin
              state_d = S_HALT;
            end else if (C_TO_EN && (cycle_d == C_TO_VAL)) begin
              state_d = S_TIMEOUT;
            end
          end
        end
        default: begin
          // HALT and TIMEOUT are sticky until clear or reset.
        end
      endcase
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cycle_q      <= '0;
      pc_prev_q    <= '0;
      rep_q        <= '0;
      snap_cycle_q <= '0;
      snap_ev_q    <= '0;
      snap_valid_q <= 1'b0;
      for (int i = 0; i < NUM_EVENTS; i++) begin
        ev_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cycle_q      <= cycle_d;
      pc_prev_q    <= pc_prev_d;
      rep_q        <= rep_d;
      snap_cycle_q <= snap_cycle_d;
      snap_ev_q    <= snap_ev_d;
      snap_valid_q <= snap_valid_d;
      for (int i = 0; i < NUM_EVENTS; i++) begin
        ev_q[i] <= ev_d[i];
      end
    end
  end

  assign cycle_count  = cycle_q;
  assign event_counts = w_ev_packed;
  assign snap_cycle   = snap_cycle_q;
  assign snap_events  = snap_ev_q;
  assign snap_valid   = snap_valid_q;
  assign running      = (state_q == S_RUN);
  assign halted       = (state_q == S_HALT);
  assign timeout      = (state_q == S_TIMEOUT);

endmodule
`default_nettype wire

// File: tb/tb_mips_perf_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_perf_monitor
// Purpose  : Self-checking bench for mips_perf_monitor. Three configurations
//            (wide default, 4-bit counters, 20-cycle watchdog) share one
//            stimulus stream and are checked every cycle against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_perf_monitor;

  localparam int P_W  [3] = '{32, 4, 16};
  localparam int P_TO [3] = '{100000, 0, 20};
  localparam int P_HR [3] = '{8, 8, 8};

  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_TO = 3;

  logic        clk = 1'b0;
  logic        reset, enable, clear, snap_req;
  logic [3:0]  event_in;
  logic [31:0] pc_IF;

  logic [31:0]  cyc_a, scyc_a;
  logic [127:0] ev_a, sev_a;
  logic         sv_a, run_a, hlt_a, to_a;
  logic [3:0]   cyc_b, scyc_b;
  logic [15:0]  ev_b, sev_b;
  logic         sv_b, run_b, hlt_b, to_b;
  logic [15:0]  cyc_c, scyc_c;
  logic [63:0]  ev_c, sev_c;
  logic         sv_c, run_c, hlt_c, to_c;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  chk_on = 1'b0;

  // Model state
  longint m_cyc [3];
  longint m_ev  [3][4];
  longint m_scyc[3];
  longint m_sev [3][4];
  longint m_pcp [3];
  int     m_rep [3];
  int     m_st  [3];
  bit     m_sv  [3];

  always #5 clk = ~clk;

  mips_perf_monitor #(.CNT_WIDTH(32), .NUM_EVENTS(4), .HALT_REPEAT(8),
                      .TIMEOUT_CYCLES(100000), .PC_WIDTH(32)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .event_in(event_in), .pc_IF(pc_IF), .snap_req(snap_req),
    .cycle_count(cyc_a), .event_counts(ev_a), .snap_cycle(scyc_a),
    .snap_events(sev_a), .snap_valid(sv_a), .running(run_a),
    .halted(hlt_a), .timeout(to_a));

  mips_perf_monitor #(.CNT_WIDTH(4), .NUM_EVENTS(4), .HALT_REPEAT(8),
                      .TIMEOUT_CYCLES(0), .PC_WIDTH(32)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .event_in(event_in), .pc_IF(pc_IF), .snap_req(snap_req),
    .cycle_count(cyc_b), .event_counts(ev_b), .snap_cycle(scyc_b),
    .snap_events(sev_b), .snap_valid(sv_b), .running(run_b),
    .halted(hlt_b), .timeout(to_b));

  mips_perf_monitor #(.CNT_WIDTH(16), .NUM_EVENTS(4), .HALT_REPEAT(8),
                      .TIMEOUT_CYCLES(20), .PC_WIDTH(32)) u_c (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .event_in(event_in), .pc_IF(pc_IF), .snap_req(snap_req),
    .cycle_count(cyc_c), .event_counts(ev_c), .snap_cycle(scyc_c),
    .snap_events(sev_c), .snap_valid(sv_c), .running(run_c),
    .halted(hlt_c), .timeout(to_c));

  task automatic cmp(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One clock edge of the monitor as described in plain terms.
  task automatic model_step(input int k);
    longint mx, ncyc;
    int     nrep;
    mx = (longint'(1) << P_W[k]) - 1;
    if (reset) begin
      m_cyc[k] = 0; m_scyc[k] = 0; m_pcp[k] = 0; m_rep[k] = 0;
      m_st[k] = M_IDLE; m_sv[k] = 1'b0;
      for (int e = 0; e < 4; e++) begin m_ev[k][e] = 0; m_sev[k][e] = 0; end
      return;
    end
    m_sv[k] = snap_req;
    if (snap_req) begin
      m_scyc[k] = m_cyc[k];
      for (int e = 0; e < 4; e++) m_sev[k][e] = m_ev[k][e];
    end
    if (clear) begin
      m_cyc[k] = 0; m_pcp[k] = 0; m_rep[k] = 0; m_st[k] = M_IDLE;
      for (int e = 0; e < 4; e++) m_ev[k][e] = 0;
    end else if (m_st[k] == M_IDLE) begin
      if (enable) m_st[k] = M_RUN;
    end else if (m_st[k] == M_RUN && enable) begin
      ncyc = (m_cyc[k] < mx) ? m_cyc[k] + 1 : mx;
      m_cyc[k] = ncyc;
      for (int e = 0; e < 4; e++)
        if (event_in[e] && m_ev[k][e] < mx) m_ev[k][e]++;
      nrep = (longint'(pc_IF) == m_pcp[k]) ? ((m_rep[k] < P_HR[k]) ? m_rep[k] + 1 : P_HR[k]) : 0;
      m_rep[k] = nrep;
      m_pcp[k] = longint'(pc_IF);
      if (nrep == P_HR[k]) m_st[k] = M_HALT;
      else if (P_TO[k] != 0 && ncyc == P_TO[k]) m_st[k] = M_TO;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
  end

  task automatic check_inst(input int k, input logic [127:0] evp, input logic [127:0] sevp,
                            input logic [31:0] cyc, input logic [31:0] scyc,
                            input logic sv, input logic rn, input logic hl, input logic to);
    logic [127:0] t;
    longint mask;
    mask = (longint'(1) << P_W[k]) - 1;
    cmp($sformatf("u%0d.cycle_count", k), longint'(cyc), m_cyc[k]);
    cmp($sformatf("u%0d.snap_cycle", k), longint'(scyc), m_scyc[k]);
    cmp($sformatf("u%0d.snap_valid", k), longint'(sv), longint'(m_sv[k]));
    cmp($sformatf("u%0d.running", k), longint'(rn), longint'(m_st[k] == M_RUN));
    cmp($sformatf("u%0d.halted", k), longint'(hl), longint'(m_st[k] == M_HALT));
    cmp($sformatf("u%0d.timeout", k), longint'(to), longint'(m_st[k] == M_TO));
    for (int e = 0; e < 4; e++) begin
      t = evp >> (e * P_W[k]);
      cmp($sformatf("u%0d.event%0d", k, e), longint'(t[63:0]) & mask, m_ev[k][e]);
      t = sevp >> (e * P_W[k]);
      cmp($sformatf("u%0d.snap_event%0d", k, e), longint'(t[63:0]) & mask, m_sev[k][e]);
    end
  endtask

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check_inst(0, ev_a, sev_a, cyc_a, scyc_a, sv_a, run_a, hlt_a, to_a);
      check_inst(1, 128'(ev_b), 128'(sev_b), 32'(cyc_b), 32'(scyc_b), sv_b, run_b, hlt_b, to_b);
      check_inst(2, 128'(ev_c), 128'(sev_c), 32'(cyc_c), 32'(scyc_c), sv_c, run_c, hlt_c, to_c);
    end
  end

  task automatic step(input logic en, input logic [3:0] ev, input logic [31:0] pc,
                      input logic sr, input logic clr);
    enable = en; event_in = ev; pc_IF = pc; snap_req = sr; clear = clr;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; snap_req = 1'b0;
    event_in = 4'd0; pc_IF = 32'd0;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    cmp("reset.cycle", longint'(cyc_a), 0);
    cmp("reset.running", longint'(run_a), 0);
    reset = 1'b0;

    // 1: count with event 0 held, PC moving
    for (int k = 0; k < 10; k++) step(1'b1, 4'b0001, 32'(4 * k), 1'b0, 1'b0);
    cmp("t1.running", longint'(run_a), 1);
    cmp("t1.cycle", longint'(cyc_a), 9);
    cmp("t1.ev0", longint'(ev_a[31:0]), 9);
    cmp("t1.ev1", longint'(ev_a[63:32]), 0);

    // 2: branch-to-self at 0x40 after five moving fetches
    step(1'b0, 4'b0000, 32'd0, 1'b0, 1'b1);
    step(1'b1, 4'b0110, 32'h100, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) step(1'b1, 4'b0110, 32'(4 * k), 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b1, 4'b0110, 32'h40, 1'b0, 1'b0);
    cmp("t2.halted", longint'(hlt_a), 1);
    cmp("t2.running", longint'(run_a), 0);
    cmp("t2.cycle", longint'(cyc_a), 14);
    cmp("t2.ev1", longint'(ev_a[63:32]), 14);

    // 3/4: watchdog at 20 and 4-bit saturation, all events firing
    step(1'b0, 4'b0000, 32'd0, 1'b0, 1'b1);
    step(1'b1, 4'b1111, 32'h200, 1'b0, 1'b0);
    for (int k = 1; k <= 25; k++) step(1'b1, 4'b1111, 32'h200 + 32'(4 * k), 1'b0, 1'b0);
    cmp("t3.timeout", longint'(to_c), 1);
    cmp("t3.cycle_c", longint'(cyc_c), 20);
    cmp("t3.cycle_a", longint'(cyc_a), 25);
    cmp("t4.cycle_b", longint'(cyc_b), 15);
    cmp("t4.ev3_b", longint'(ev_b[15:12]), 15);

    // 3b: halt and watchdog on the same edge -> halt wins
    step(1'b0, 4'b0000, 32'd0, 1'b0, 1'b1);
    step(1'b1, 4'b0000, 32'h1000, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) step(1'b1, 4'b0000, 32'h1000 + 32'(4 * k), 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, 4'b0000, 32'h1030, 1'b0, 1'b0);
    cmp("t3b.halted_c", longint'(hlt_c), 1);
    cmp("t3b.timeout_c", longint'(to_c), 0);
    cmp("t3b.cycle_c", longint'(cyc_c), 20);

    // 5: snapshot together with clear, then back-to-back snapshots
    step(1'b0, 4'b0000, 32'd0, 1'b0, 1'b1);
    step(1'b1, 4'b0101, 32'h300, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) step(1'b1, 4'b0101, 32'h300 + 32'(4 * k), 1'b0, 1'b0);
    step(1'b1, 4'b0101, 32'h400, 1'b1, 1'b1);
    cmp("t5.snap_valid", longint'(sv_a), 1);
    cmp("t5.snap_cycle", longint'(scyc_a), 12);
    cmp("t5.snap_ev2", longint'(sev_a[95:64]), 12);
    cmp("t5.cycle", longint'(cyc_a), 0);
    cmp("t5.running", longint'(run_a), 0);
    step(1'b0, 4'b0000, 32'd0, 1'b1, 1'b0);
    cmp("t5.b2b_1", longint'(sv_a), 1);
    step(1'b0, 4'b0000, 32'd0, 1'b1, 1'b0);
    cmp("t5.b2b_2", longint'(sv_a), 1);
    step(1'b0, 4'b0000, 32'd0, 1'b0, 1'b0);
    cmp("t5.b2b_end", longint'(sv_a), 0);

    // 6: enable dropped mid-run with a stable PC
    step(1'b1, 4'b1000, 32'h80, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 4'b1000, 32'h80, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1'b0, 4'b1000, 32'h80, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, 4'b1000, 32'h80, 1'b0, 1'b0);
    cmp("t6.cycle", longint'(cyc_a), 7);
    cmp("t6.halted", longint'(hlt_a), 0);
    cmp("t6.running", longint'(run_a), 1);
    step(1'b1, 4'b1000, 32'h80, 1'b0, 1'b0);
    step(1'b1, 4'b1000, 32'h80, 1'b0, 1'b0);
    cmp("t6.halt_late", longint'(hlt_a), 1);

    // Mixed traffic checked only by the model
    step(1'b0, 4'b0000, 32'd0, 1'b0, 1'b1);
    for (int k = 0; k < 60; k++)
      step(($urandom_range(0, 7) != 0), 4'($urandom), 32'($urandom_range(0, 1) * 4),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));

    // Reset mid-run
    step(1'b1, 4'b1111, 32'h10, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 32'h14, 1'b1, 1'b0);
    reset = 1'b1;
    step(1'b1, 4'b1111, 32'h18, 1'b0, 1'b0);
    cmp("t6.rst_cycle", longint'(cyc_a), 0);
    cmp("t6.rst_snap", longint'(scyc_a), 0);
    cmp("t6.rst_running", longint'(run_a), 0);
    reset = 1'b0;
    step(1'b0, 4'b0000, 32'd0, 1'b0, 1'b0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
